alu_op_sequencer: RTL and testbench

Multi-cycle sequencer that drives the 4×8-bit register bank and the 2-bit-opcode ALU from a single command port. It accepts one command at a time: read two registers, execute, optionally write back, then report. It also arbitrates keypad-load writes into the same register bank. It sits between the top-level pin decode and the register bank / ALU pair, replacing direct pin-to-datapath wiring.

---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/alu_op_sequencer_if.sv | 75 +++++++
 rtl/alu_seq_stats.sv | 46 ++++
 rtl/alu_op_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and defaults for the ALU operation sequencer.
// Optional feature macro: ALU_SEQ_STATS_EN (completed-command statistics).
package alu_seq_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;
  localparam int KEY_PAD_W  = 4;

  // Sequencer control states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_KEY  = 3'd1,
    ST_READ = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4,
    ST_DONE = 3'd5
  } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: command, keypad, register-bank, ALU, result and
// statistics signals of the sequencer. The slave modport is the sequencer
// view; the master modport is the surrounding system view.
interface alu_op_sequencer_if
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [ADDR_W-1:0]    cmd_src_a;
  logic [ADDR_W-1:0]    cmd_src_b;
  logic [ADDR_W-1:0]    cmd_dst;
  logic                 cmd_wb;

  logic                 key_valid;
  logic                 key_ready;
  logic [KEY_PAD_W-1:0] key_data;
  logic [ADDR_W-1:0]    key_dst;

  logic [ADDR_W-1:0]    rf_addr_a;
  logic [ADDR_W-1:0]    rf_addr_b;
  logic [DATA_W-1:0]    rf_doa;
  logic [DATA_W-1:0]    rf_dob;
  logic                 rf_we;
  logic [ADDR_W-1:0]    rf_addr_wr;
  logic [DATA_W-1:0]    rf_wdata;

  logic [DATA_W-1:0]    alu_a;
  logic [DATA_W-1:0]    alu_b;
  logic [1:0]           alu_sel;
  logic [DATA_W-1:0]    alu_result;
  logic                 alu_carry;
  logic                 alu_zero;

  logic                 res_valid;
  logic                 res_ready;
  logic [DATA_W-1:0]    res_data;
  logic                 res_carry;
  logic                 res_zero;

  logic [7:0]           stat_ops;
  logic                 stat_carry;

  modport slave (
    input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_wb,
    output cmd_ready,
    input  key_valid, key_data, key_dst,
    output key_ready,
    output rf_addr_a, rf_addr_b, rf_we, rf_addr_wr, rf_wdata,
    input  rf_doa, rf_dob,
    output alu_a, alu_b, alu_sel,
    input  alu_result, alu_carry, alu_zero,
    output res_valid, res_data, res_carry, res_zero,
    input  res_ready,
    output stat_ops, stat_carry
  );

  modport master (
    output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_wb,
    input  cmd_ready,
    output key_valid, key_data, key_dst,
    input  key_ready,
    input  rf_addr_a, rf_addr_b, rf_we, rf_addr_wr, rf_wdata,
    output rf_doa, rf_dob,
    input  alu_a, alu_b, alu_sel,
    output alu_result, alu_carry, alu_zero,
    input  res_valid, res_data, res_carry, res_zero,
    output res_ready,
    input  stat_ops, stat_carry
  );

endinterface

// File: rtl/alu_seq_stats.sv
// alu_seq_stats: completed-command counter (wraps 255->0) and sticky carry
// flag. Only instantiated when ALU_SEQ_STATS_EN is defined.
module alu_seq_stats (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       done_i,
  input  logic       carry_i,
  output logic [7:0] stat_ops_o,
  output logic       stat_carry_o
);

  logic [7:0] ops_q, ops_d;
  logic       sticky_q, sticky_d;

  // Next-state: count each completed command, latch any completing carry
  always_comb begin
    ops_d    = ops_q;
    sticky_d = sticky_q;
    if (done_i) begin
      ops_d = ops_q + 8'd1;
      if (carry_i) begin
        sticky_d = 1'b1;
      end else begin
        sticky_d = sticky_q;
      end
    end else begin
      ops_d    = ops_q;
      sticky_d = sticky_q;
    end
  end

  // Statistic registers, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q    <= 8'd0;
      sticky_q <= 1'b0;
    end else begin
      ops_q    <= ops_d;
      sticky_q <= sticky_d;
    end
  end

  assign stat_ops_o   = ops_q;
  assign stat_carry_o = sticky_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: multi-cycle sequencer driving an external register bank
// and ALU from one command port, with keypad writes taking priority in IDLE.
// Command flow: accept -> READ -> EXEC -> WB -> DONE (fixed latency).
// Optional feature macro: ALU_SEQ_STATS_EN enables stat_ops / stat_carry.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_op_sequencer_if.slave  bus
);

  seq_state_e state_q, state_d;

  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic              wb_q, wb_d;

  logic [ADDR_W-1:0] rf_addr_a_q, rf_addr_a_d;
  logic [ADDR_W-1:0] rf_addr_b_q, rf_addr_b_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_wr_q, rf_addr_wr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic [1:0]        alu_sel_q, alu_sel_d;

  logic              key_ready_q, key_ready_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              res_carry_q, res_carry_d;
  logic              res_zero_q, res_zero_d;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output logic; every output is registered so the
  // values presented in a state are loaded on the edge entering it
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    dst_d        = dst_q;
    wb_d         = wb_q;
    rf_addr_a_d  = rf_addr_a_q;
    rf_addr_b_d  = rf_addr_b_q;
    rf_we_d      = 1'b0;
    rf_addr_wr_d = rf_addr_wr_q;
    rf_wdata_d   = rf_wdata_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    key_ready_d  = 1'b0;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_carry_d  = res_carry_q;
    res_zero_d   = res_zero_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.key_valid) begin
          // Keypad wins over a simultaneous command
          state_d      = ST_KEY;
          rf_we_d      = 1'b1;
          rf_addr_wr_d = bus.key_dst;
          rf_wdata_d   = {{(DATA_W-KEY_PAD_W){1'b0}}, bus.key_data};
          key_ready_d  = 1'b1;
        end else if (bus.cmd_valid) begin
          // Read addresses go out on entry to READ so data is ready there
          state_d     = ST_READ;
          op_d        = bus.cmd_op;
          dst_d       = bus.cmd_dst;
          wb_d        = bus.cmd_wb;
          rf_addr_a_d = bus.cmd_src_a;
          rf_addr_b_d = bus.cmd_src_b;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_KEY: begin
        state_d = ST_IDLE;
      end
      ST_READ: begin
        state_d   = ST_EXEC;
        alu_a_d   = bus.rf_doa;
        alu_b_d   = bus.rf_dob;
        alu_sel_d = op_q;
      end
      ST_EXEC: begin
        // Result and flags captured once; the write-back uses the same copy
        state_d      = ST_WB;
        res_data_d   = bus.alu_result;
        res_carry_d  = bus.alu_carry;
        res_zero_d   = bus.alu_zero;
        rf_wdata_d   = bus.alu_result;
        rf_addr_wr_d = dst_q;
        rf_we_d      = wb_q;
      end
      ST_WB: begin
        state_d     = ST_DONE;
        res_valid_d = 1'b1;
      end
      ST_DONE: begin
        if (bus.res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
        end else begin
          state_d     = ST_DONE;
          res_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q         <= 2'd0;
      dst_q        <= {ADDR_W{1'b0}};
      wb_q         <= 1'b0;
      rf_addr_a_q  <= {ADDR_W{1'b0}};
      rf_addr_b_q  <= {ADDR_W{1'b0}};
      rf_we_q      <= 1'b0;
      rf_addr_wr_q <= {ADDR_W{1'b0}};
      rf_wdata_q   <= {DATA_W{1'b0}};
      alu_a_q      <= {DATA_W{1'b0}};
      alu_b_q      <= {DATA_W{1'b0}};
      alu_sel_q    <= 2'd0;
      key_ready_q  <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= {DATA_W{1'b0}};
      res_carry_q  <= 1'b0;
      res_zero_q   <= 1'b0;
    end else begin
      op_q         <= op_d;
      dst_q        <= dst_d;
      wb_q         <= wb_d;
      rf_addr_a_q  <= rf_addr_a_d;
      rf_addr_b_q  <= rf_addr_b_d;
      rf_we_q      <= rf_we_d;
      rf_addr_wr_q <= rf_addr_wr_d;
      rf_wdata_q   <= rf_wdata_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      key_ready_q  <= key_ready_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_carry_q  <= res_carry_d;
      res_zero_q   <= res_zero_d;
    end
  end

  // cmd_ready must drop in the same cycle a keypad request appears
  assign bus.cmd_ready  = rst_n & (state_q == ST_IDLE) & ~bus.key_valid;
  assign bus.key_ready  = key_ready_q;
  assign bus.rf_addr_a  = rf_addr_a_q;
  assign bus.rf_addr_b  = rf_addr_b_q;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_addr_wr = rf_addr_wr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_sel    = alu_sel_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_carry  = res_carry_q;
  assign bus.res_zero   = res_zero_q;

`ifdef ALU_SEQ_STATS_EN
  logic done_fire_s;

  assign done_fire_s = (state_q == ST_DONE) & bus.res_ready;

  alu_seq_stats u_stats (
    .clk          (clk),
    .rst_n        (rst_n),
    .done_i       (done_fire_s),
    .carry_i      (res_carry_q),
    .stat_ops_o   (bus.stat_ops),
    .stat_carry_o (bus.stat_carry)
  );
`else
  assign bus.stat_ops   = 8'd0;
  assign bus.stat_carry = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: randomized scoreboard bench. A driver issues keypad
// writes and commands and pushes expected results computed from a shadow
// register file; a monitor pops and compares whenever res_valid appears.
module tb_alu_op_sequencer;

  localparam int DW = 8;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_op_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  alu_op_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- environment: register bank and ALU ----------------
  logic [7:0] rf [4];
  logic       rf_clear = 1'b1;
  logic [8:0] alu_t;
  logic       res_ready_tb = 1'b0;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
    end else if (bus.rf_we) begin
      rf[bus.rf_addr_wr] <= bus.rf_wdata;
    end
  end

  assign bus.rf_doa    = rf[bus.rf_addr_a];
  assign bus.rf_dob    = rf[bus.rf_addr_b];
  assign bus.res_ready = res_ready_tb;

  always_comb begin
    alu_t = 9'd0;
    case (bus.alu_sel)
      2'b00:   alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      2'b01:   alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      2'b10:   alu_t = {1'b0, bus.alu_a & bus.alu_b};
      default: alu_t = {1'b0, bus.alu_a ^ bus.alu_b};
    endcase
  end
  assign bus.alu_result = alu_t[7:0];
  assign bus.alu_carry  = alu_t[8];
  assign bus.alu_zero   = (alu_t[7:0] == 8'h00);

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    logic [7:0] d;
    logic       c;
    logic       z;
    int         cyc;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] mrf [4];
  int         n_checks = 0;
  int         n_fail = 0;
  bit         stall_next = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Behavioural ALU: 0 ADD, 1 SUB (carry = borrow), 2 AND, 3 XOR
  task automatic model_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           output logic [7:0] r, output logic c, output logic z);
    int s;
    c = 1'b0;
    case (op)
      2'd0: begin s = int'(a) + int'(b); c = (s > 255); s = s % 256; end
      2'd1: begin s = int'(a) - int'(b); c = (s < 0); if (s < 0) s = s + 256; end
      2'd2: s = int'(a & b);
      default: s = int'(a ^ b);
    endcase
    r = s[7:0];
    z = (s == 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic key_write(input logic [3:0] d, input logic [1:0] dst);
    int t = 0;
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_data  = d;
    bus.key_dst   = dst;
    @(negedge clk);
    while (!bus.key_ready && t < 200) begin @(negedge clk); t++; end
    if (!bus.key_ready) begin
      timeout_fail("key_accept");
    end else begin
      check("key_we", {31'd0, bus.rf_we}, 32'd1);
      check("key_wdata", {24'd0, bus.rf_wdata}, {28'd0, d});
      check("key_waddr", {30'd0, bus.rf_addr_wr}, {30'd0, dst});
      mrf[dst] = {4'h0, d};
    end
    bus.key_valid = 1'b0;
    @(negedge clk);
    check("key_ready_pulse", {31'd0, bus.key_ready}, 32'd0);
  endtask

  task automatic accept_cmd(input logic [1:0] op, input logic [1:0] sa, input logic [1:0] sb,
                            input logic [1:0] dst, input logic wb, input bit push, output int acc);
    int t = 0;
    exp_t e;
    logic [7:0] r;
    logic c, z;
    #1;
    while (!bus.cmd_ready && t < 200) begin @(negedge clk); #1; t++; end
    if (!bus.cmd_ready) begin
      timeout_fail("cmd_accept");
      bus.cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    bus.cmd_valid = 1'b0;
    if (push) begin
      model_alu(op, mrf[sa], mrf[sb], r, c, z);
      e.d = r; e.c = c; e.z = z; e.cyc = acc;
      expq.push_back(e);
      if (wb) mrf[dst] = r;
    end
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [1:0] sa, input logic [1:0] sb,
                           input logic [1:0] dst, input logic wb, input bit push, output int acc);
    @(negedge clk);
    bus.cmd_op    = op;
    bus.cmd_src_a = sa;
    bus.cmd_src_b = sb;
    bus.cmd_dst   = dst;
    bus.cmd_wb    = wb;
    bus.cmd_valid = 1'b1;
    accept_cmd(op, sa, sb, dst, wb, push, acc);
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk); #1;
    while (!(bus.cmd_ready && expq.size() == 0) && t < 300) begin @(negedge clk); #1; t++; end
    if (!(bus.cmd_ready && expq.size() == 0)) timeout_fail("wait_idle");
  endtask

  // ---------------- monitor ----------------
  exp_t       cur;
  bit         seen = 1'b0;
  bit         cur_ok = 1'b0;
  bit         released_last = 1'b0;
  int         stall_left = 0;
  logic [7:0] exp_ops = 8'd0;
  logic       exp_sticky = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      res_ready_tb  = 1'b0;
      seen          = 1'b0;
      released_last = 1'b0;
      exp_ops       = 8'd0;
      exp_sticky    = 1'b0;
    end else begin
`ifdef ALU_SEQ_STATS_EN
      check("stat_ops", {24'd0, bus.stat_ops}, {24'd0, exp_ops});
      check("stat_carry", {31'd0, bus.stat_carry}, {31'd0, exp_sticky});
`else
      check("stat_ops_off", {24'd0, bus.stat_ops}, 32'd0);
      check("stat_carry_off", {31'd0, bus.stat_carry}, 32'd0);
`endif
      if (released_last) begin
        check("res_release", {31'd0, bus.res_valid}, 32'd0);
        released_last = 1'b0;
        res_ready_tb  = 1'b0;
        seen          = 1'b0;
      end else if (bus.res_valid) begin
        if (!seen) begin
          seen = 1'b1;
          if (expq.size() == 0) begin
            timeout_fail("res_unexpected");
            cur_ok = 1'b0;
          end else begin
            cur    = expq.pop_front();
            cur_ok = 1'b1;
            check("res_latency", cyc, cur.cyc + 3);
          end
          stall_left = stall_next ? 10 : int'($urandom_range(0, 2));
          stall_next = 1'b0;
        end
        if (cur_ok) begin
          check("res_data", {24'd0, bus.res_data}, {24'd0, cur.d});
          check("res_carry", {31'd0, bus.res_carry}, {31'd0, cur.c});
          check("res_zero", {31'd0, bus.res_zero}, {31'd0, cur.z});
        end
        check("cmd_ready_busy", {31'd0, bus.cmd_ready}, 32'd0);
        if (stall_left == 0) begin
          res_ready_tb  = 1'b1;
          released_last = 1'b1;
          exp_ops       = exp_ops + 8'd1;
          if (cur_ok && cur.c) exp_sticky = 1'b1;
        end else begin
          stall_left--;
          res_ready_tb = 1'b0;
        end
      end else begin
        if (seen) timeout_fail("res_valid_dropped");
        seen         = 1'b0;
        res_ready_tb = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int kc;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_src_a = 2'd0; bus.cmd_src_b = 2'd0;
    bus.cmd_dst = 2'd0; bus.cmd_wb = 1'b0;
    bus.key_valid = 1'b0; bus.key_data = 4'h0; bus.key_dst = 2'd0;
    for (int i = 0; i < 4; i++) mrf[i] = 8'h00;

    // Reset state
    #2;
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst_rf_we", {31'd0, bus.rf_we}, 32'd0);
    check("rst_key_ready", {31'd0, bus.key_ready}, 32'd0);
    check("rst_res_data", {24'd0, bus.res_data}, 32'd0);
    check("rst_stat_ops", {24'd0, bus.stat_ops}, 32'd0);
    repeat (3) @(negedge clk);
    rf_clear = 1'b0;
    rst_n = 1'b1;
    #1;
    check("post_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

    // Directed: keypad loads, ADD with write-back, SUB without write-back
    key_write(4'hA, 2'd1);
    key_write(4'h7, 2'd2);
    issue_cmd(2'd0, 2'd1, 2'd2, 2'd3, 1'b1, 1'b1, acc);
    issue_cmd(2'd1, 2'd2, 2'd2, 2'd0, 1'b0, 1'b1, acc);
    repeat (4) begin
      @(negedge clk);
      check("nowb_rf_we", {31'd0, bus.rf_we}, 32'd0);
    end
    wait_idle();
    check("r3_after_add", {24'd0, rf[3]}, 32'h11);
    check("r0_after_nowb", {24'd0, rf[0]}, 32'h00);

    // Keypad and command together: keypad first, command next IDLE cycle
    @(negedge clk);
    bus.key_valid = 1'b1; bus.key_data = 4'h5; bus.key_dst = 2'd0;
    bus.cmd_op = 2'd0; bus.cmd_src_a = 2'd0; bus.cmd_src_b = 2'd1;
    bus.cmd_dst = 2'd2; bus.cmd_wb = 1'b1; bus.cmd_valid = 1'b1;
    #1;
    check("both_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    @(negedge clk);
    check("both_key_first", {31'd0, bus.key_ready}, 32'd1);
    kc = cyc;
    mrf[0] = 8'h05;
    bus.key_valid = 1'b0;
    accept_cmd(2'd0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b1, acc);
    check("both_cmd_after_key", acc, kc + 2);
    wait_idle();

    // Long consumer stall
    stall_next = 1'b1;
    issue_cmd(2'd1, 2'd1, 2'd0, 2'd3, 1'b1, 1'b1, acc);
    wait_idle();

    // Randomized mix
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        key_write(4'($urandom), 2'($urandom));
      end else begin
        issue_cmd(2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                  1'($urandom), 1'b1, acc);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    for (int i = 0; i < 4; i++) check("rf_final", {24'd0, rf[i]}, {24'd0, mrf[i]});

    // Reset during WB aborts the write
    key_write(4'hF, 2'd0);
    key_write(4'h1, 2'd1);
    key_write(4'h2, 2'd2);
    issue_cmd(2'd0, 2'd1, 2'd2, 2'd0, 1'b1, 1'b0, acc);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("abort_in_wb", {31'd0, bus.rf_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_rf_we", {31'd0, bus.rf_we}, 32'd0);
    check("abort_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("abort_stat_ops", {24'd0, bus.stat_ops}, 32'd0);
    check("abort_stat_carry", {31'd0, bus.stat_carry}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("abort_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
    check("abort_dst", {24'd0, rf[0]}, 32'h0F);

    // Operation resumes after reset
    issue_cmd(2'd0, 2'd0, 2'd1, 2'd3, 1'b1, 1'b1, acc);
    wait_idle();
    for (int i = 0; i < 4; i++) check("rf_end", {24'd0, rf[i]}, {24'd0, mrf[i]});

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global bound on run time
  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end

endmodule
